m_wbuart_rx: RTL and testbench



---
 rtl/m_wbuart_rx_if.sv | 20 ++
 rtl/m_wbuart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_m_wbuart_rx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_wbuart_rx_if.sv
// Wishbone bus bundle for the UART receiver; names follow the slave's view of the bus.
interface m_wbuart_rx_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic        ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/m_wbuart_rx.sv
// m_wbuart_rx: Wishbone-slave 8N1 UART receiver with a small byte FIFO and two word registers.
module m_wbuart_rx #(
    parameter int unsigned DIVISOR   = 287,
    parameter int unsigned DEPTHLOG2 = 2
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    m_wbuart_rx_if.slave wb,
    input  logic         usartRX,
    output logic         rxready
);
    localparam int unsigned     Depth   = 1 << DEPTHLOG2;
    localparam int unsigned     CntW    = DEPTHLOG2 + 1;
    localparam logic [15:0]     DivFull = 16'(DIVISOR);
    localparam logic [15:0]     DivHalf = 16'(DIVISOR / 2);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    // Synchroniser and receiver
    logic        sync_q, rxs_q;
    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        expired, push_req, ferr_set;

    // FIFO
    logic [7:0]           mem_q [Depth];
    logic [DEPTHLOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 empty, full, push_ok, pop_ok;

    // Flags and bus
    logic        ovr_q, ovr_d, ferr_q, ferr_d;
    logic        ack_q, ack_d, rxready_q;
    logic        bus_req, access, pop_req, clr_ovr, clr_ferr;
    logic [7:0]  head;
    logic [31:0] dat_o;
    logic        unused_dat;

    assign unused_dat = ^{wb.DAT_I[31:4], wb.DAT_I[1:0]};

    // Two-stage synchroniser for the asynchronous line; both stages idle high.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= usartRX;
            rxs_q  <= sync_q;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Receiver next state; a sample is taken at the edge that ends the cycle where timer is 1.
    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != 16'd0) ? timer_q - 16'd1 : timer_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        expired  = (timer_q == 16'd1);
        case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    timer_d = DivHalf;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (expired) begin
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        timer_d = DivFull;
                        idx_d   = 3'd0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (expired) begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    timer_d = DivFull;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (expired) begin
                    if (rxs_q) begin
                        push_req = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    state_d = rxs_q ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus decode, FIFO bookkeeping and sticky flags; a pop frees room for a same-cycle push.
    always_comb begin
        bus_req  = wb.CYC_I & wb.STB_I;
        ack_d    = bus_req & ~ack_q;
        access   = ack_q & bus_req;
        pop_req  = access & ~wb.WE_I & ~wb.ADR_I;
        clr_ovr  = access & wb.WE_I & wb.ADR_I & wb.DAT_I[2];
        clr_ferr = access & wb.WE_I & wb.ADR_I & wb.DAT_I[3];
        empty    = (cnt_q == '0);
        full     = (cnt_q == CntFull);
        pop_ok   = pop_req & ~empty;
        push_ok  = push_req & (~full | pop_ok);
        wptr_d   = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop_ok ? rptr_q + 1'b1 : rptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Set beats clear when both land in the same cycle.
        ovr_d  = (ovr_q & ~clr_ovr) | (push_req & full & ~pop_ok);
        ferr_d = (ferr_q & ~clr_ferr) | ferr_set;
    end

    // FIFO pointers, count, flags and the registered bus acknowledge.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ack_q     <= 1'b0;
            rxready_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            ack_q     <= ack_d;
            rxready_q <= ~empty;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge CLK_I) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shreg_q;
        end
    end

    // Read data mux; forced to zero outside the ACK cycle.
    always_comb begin
        head  = empty ? 8'h00 : mem_q[rptr_q];
        dat_o = '0;
        if (ack_q) begin
            if (wb.ADR_I) begin
                dat_o[0]   = ~empty;
                dat_o[1]   = full;
                dat_o[2]   = ovr_q;
                dat_o[3]   = ferr_q;
                dat_o[8:4] = 5'(cnt_q);
            end else begin
                dat_o[8]   = ~empty;
                dat_o[7:0] = head;
            end
        end
    end

    assign wb.DAT_O = dat_o;
    assign wb.ACK_O = ack_q;
    assign rxready  = rxready_q;
endmodule

// File: tb/tb_m_wbuart_rx.sv
// Self-checking bench for m_wbuart_rx: queue-based receiver model plus directed frames.
module tb_m_wbuart_rx;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line;
    logic rxready;

    m_wbuart_rx_if wbif ();

    m_wbuart_rx #(
        .DIVISOR   (DIV),
        .DEPTHLOG2 (2)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .wb      (wbif.slave),
        .usartRX (rx_line),
        .rxready (rxready)
    );

    initial forever #5 clk = ~clk;

    // Model state: bytes held, sticky flags, delayed non-empty indication.
    logic [7:0] m_q [$];
    bit         m_ovr, m_ferr, m_rdy;
    int         edge_n = 0;

    // Events the stimulus schedules for the model, keyed by clock edge number.
    int         ev_push_edge = -1;
    logic [7:0] ev_push_byte;
    bit         ev_push_good;
    int         ev_bus_edge = -1;
    bit         ev_bus_pop;
    bit [1:0]   ev_bus_clr;
    bit         exp_ack, exp_adr, exp_we;

    int         rise_edge = -1;
    int         t_start = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_view(input bit adr);
        logic [31:0] v;
        int n;
        v = '0;
        n = m_q.size();
        if (adr) begin
            v[0]   = (n != 0);
            v[1]   = (n == DEPTH);
            v[2]   = m_ovr;
            v[3]   = m_ferr;
            v[8:4] = 5'(n);
        end else if (n != 0) begin
            v[8]   = 1'b1;
            v[7:0] = m_q[0];
        end
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Per edge: pops and clears land first, then the frame outcome.
    task automatic model_loop();
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst_n) begin
                m_q.delete();
                m_ovr = 1'b0;
                m_ferr = 1'b0;
                m_rdy = 1'b0;
            end else begin
                m_rdy = (m_q.size() != 0);
                if (ev_bus_edge == edge_n) begin
                    if (ev_bus_pop && m_q.size() != 0) void'(m_q.pop_front());
                    if (ev_bus_clr[0]) m_ovr = 1'b0;
                    if (ev_bus_clr[1]) m_ferr = 1'b0;
                end
                if (ev_push_edge == edge_n) begin
                    if (!ev_push_good) m_ferr = 1'b1;
                    else if (m_q.size() < DEPTH) m_q.push_back(ev_push_byte);
                    else m_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_loop();
        logic rx_prev;
        logic [31:0] exp_dat;
        rx_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("rxready", 32'(rxready), 32'(rst_n && m_rdy));
            check("ACK_O", 32'(wbif.ACK_O), 32'(exp_ack));
            if (!(exp_ack && exp_we)) begin
                exp_dat = exp_ack ? model_view(exp_adr) : 32'h0;
                check("DAT_O", wbif.DAT_O, exp_dat);
            end
            if (rxready && !rx_prev) rise_edge = edge_n;
            rx_prev = rxready;
        end
    endtask

    task automatic wb_access(input bit we, input bit adr, input logic [31:0] wd,
                             output logic [31:0] rd);
        wbif.CYC_I = 1'b1;
        wbif.STB_I = 1'b1;
        wbif.WE_I  = we;
        wbif.ADR_I = adr;
        wbif.DAT_I = wd;
        tick(1);
        exp_we      = we;
        exp_adr     = adr;
        exp_ack     = 1'b1;
        ev_bus_pop  = !we && !adr;
        ev_bus_clr  = (we && adr) ? wd[3:2] : 2'b00;
        ev_bus_edge = edge_n + 1;
        #3;
        rd = wbif.DAT_O;
        tick(1);
        wbif.CYC_I = 1'b0;
        wbif.STB_I = 1'b0;
        wbif.WE_I  = 1'b0;
        exp_ack    = 1'b0;
    endtask

    // Sends start, 8 data bits LSB-first, stop; abort_bits >= 0 stops after that many bits.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bits);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t_start      = edge_n + 1;
        ev_push_byte = b;
        ev_push_good = stop;
        ev_push_edge = t_start + 2 + DIV / 2 + 9 * DIV;
        for (int i = 0; i < 10; i++) begin
            if (abort_bits == i) return;
            rx_line = bits[i];
            tick(DIV);
        end
        rx_line = 1'b1;
    endtask

    logic [31:0] rd;
    int guard;

    initial begin
        rst_n      = 1'b0;
        rx_line    = 1'b1;
        wbif.CYC_I = 1'b0;
        wbif.STB_I = 1'b0;
        wbif.WE_I  = 1'b0;
        wbif.ADR_I = 1'b0;
        wbif.DAT_I = '0;
        fork
            model_loop();
            compare_loop();
            begin
                #2000000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1);
            end
        join_none

        // Reset values
        tick(3);
        check("reset rxready", 32'(rxready), 32'h0);
        check("reset ACK_O", 32'(wbif.ACK_O), 32'h0);
        check("reset DAT_O", wbif.DAT_O, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Reset between data bits 3 and 4 of 0xA7 abandons the frame
        tick(5);
        send_frame(8'hA7, 1'b1, 5);
        ev_push_edge = -1;
        rst_n = 1'b0;
        rx_line = 1'b1;
        #2;
        check("midframe reset rxready", 32'(rxready), 32'h0);
        check("midframe reset DAT_O", wbif.DAT_O, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(200);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status after reset", rd, 32'h000);
        check("rxready after reset", 32'(rxready), 32'h0);

        // Single frame 0x55
        tick(5);
        send_frame(8'h55, 1'b1, -1);
        tick(5);
        check("rxready latency", 32'(rise_edge - t_start), 32'd155);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x55", rd, 32'h155);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata empty", rd, 32'h000);

        // False start shorter than half a bit
        rx_line = 1'b0;
        tick(5);
        rx_line = 1'b1;
        tick(30);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status after false start", rd, 32'h000);
        send_frame(8'h3C, 1'b1, -1);
        tick(5);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x3C", rd, 32'h13C);

        // Framing error then a good byte
        send_frame(8'h81, 1'b0, -1);
        tick(20);
        send_frame(8'h42, 1'b1, -1);
        tick(5);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status ferr", rd, 32'h019);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x42", rd, 32'h142);
        wb_access(1'b1, 1'b1, 32'h8, rd);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status ferr cleared", rd, 32'h000);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
        tick(5);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status overrun", rd, 32'h047);
        for (int i = 1; i <= 4; i++) begin
            wb_access(1'b0, 1'b0, 32'h0, rd);
            check("rxdata overrun order", rd, 32'h100 + 32'(i));
        end
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status ovr sticky", rd, 32'h004);
        wb_access(1'b1, 1'b1, 32'h4, rd);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status ovr cleared", rd, 32'h000);

        // Full FIFO: pop coincides with the stop-bit sample of 0x77
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        send_frame(8'h33, 1'b1, -1);
        send_frame(8'h44, 1'b1, -1);
        tick(5);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status full", rd, 32'h043);
        fork
            send_frame(8'h77, 1'b1, -1);
            begin
                tick(1);
                guard = 0;
                while (edge_n < ev_push_edge - 2 && guard < 400) begin
                    tick(1);
                    guard++;
                end
                check("push/pop alignment", 32'(edge_n), 32'(ev_push_edge - 2));
                wb_access(1'b0, 1'b0, 32'h0, rd);
                check("rxdata at stop sample", rd, 32'h111);
            end
        join
        tick(10);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status after push/pop", rd, 32'h043);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x22", rd, 32'h122);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x33", rd, 32'h133);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x44", rd, 32'h144);
        wb_access(1'b0, 1'b0, 32'h0, rd);
        check("rxdata 0x77 last", rd, 32'h177);
        wb_access(1'b0, 1'b1, 32'h0, rd);
        check("status drained", rd, 32'h000);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
